// File: rtl/counter_pkg.sv
// Shared types for bounded_load_counter: terminal-mode encoding and direction codes.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP_BOUND = 2'b00,
    WRAP_LOAD  = 2'b01,
    SATURATE   = 2'b10,
    ONE_SHOT   = 2'b11
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/bounded_load_counter.sv
// Loadable up/down counter with programmable bounds and selectable terminal behaviour
// (wrap to bound, reload, saturate, one-shot).
module bounded_load_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             bound_err_o
);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             done_reg, done_next;
  logic             bound_err;
  logic             count_up;
  logic             terminal;
  logic             advance;
  cnt_mode_e        mode;

  always_comb begin
    bound_err  = (lo_i > hi_i);
    count_up   = (dir_i == DIR_UP);
    mode       = cnt_mode_e'(mode_i);
    // Inclusive compares let an out-of-range loaded value terminate immediately.
    terminal   = count_up ? (count_reg >= hi_i) : (count_reg <= lo_i);
    advance    = en_i & ~bound_err & ~done_reg;

    count_next = count_reg;
    tc_next    = 1'b0;
    done_next  = done_reg;

    if (load_i) begin
      count_next = load_val_i;
      done_next  = 1'b0;
    end else if (advance) begin
      if (!terminal) begin
        count_next = count_up ? (count_reg + WIDTH'(1)) : (count_reg - WIDTH'(1));
      end else begin
        tc_next = 1'b1;
        case (mode)
          WRAP_BOUND: count_next = count_up ? lo_i : hi_i;
          WRAP_LOAD:  count_next = load_val_i;
          SATURATE:   count_next = count_up ? hi_i : lo_i;
          ONE_SHOT: begin
            count_next = count_up ? hi_i : lo_i;
            done_next  = 1'b1;
          end
          default:    count_next = count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= WIDTH'(RESET_VAL);
      tc_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      done_reg  <= done_next;
    end
  end

  assign count_o     = count_reg;
  assign tc_o        = tc_reg;
  assign done_o      = done_reg;
  assign bound_err_o = bound_err;

endmodule : bounded_load_counter

// File: tb/tb_bounded_load_counter.sv
// Directed self-checking bench for bounded_load_counter (WIDTH=4, RESET_VAL=3).
module tb_bounded_load_counter;
  import counter_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_i;
  logic         load_i;
  logic [W-1:0] load_val_i;
  logic         dir_i;
  logic [1:0]   mode_i;
  logic [W-1:0] lo_i;
  logic [W-1:0] hi_i;
  logic [W-1:0] count_o;
  logic         tc_o;
  logic         done_o;
  logic         bound_err_o;

  int checks = 0;
  int errors = 0;

  bounded_load_counter #(.WIDTH(W), .RESET_VAL(3)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i), .load_val_i(load_val_i),
    .dir_i(dir_i), .mode_i(mode_i), .lo_i(lo_i), .hi_i(hi_i),
    .count_o(count_o), .tc_o(tc_o), .done_o(done_o), .bound_err_o(bound_err_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_i = 1'b1; load_val_i = v; en_i = 1'b0;
    step();
    load_i = 1'b0;
    $display("load %0d -> count=%0d tc=%0d done=%0d", v, count_o, tc_o, done_o);
  endtask

  task automatic test_reset();
    reset = 1'b1; en_i = 0; load_i = 0; load_val_i = 0; dir_i = DIR_UP;
    mode_i = WRAP_LOAD; lo_i = 0; hi_i = 15;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    $display("reset: count=%0d tc=%0d done=%0d", count_o, tc_o, done_o);
    checks++;
    if (count_o !== 4'd3 || tc_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got count=%0d tc=%0d done=%0d want 3/0/0", count_o, tc_o, done_o);
    end
    // Count up to 9 then hit reset between edges.
    do_load(4'd7);
    en_i = 1'b1;
    step(); step();
    checks++;
    if (count_o !== 4'd9) begin
      errors++;
      $display("FAIL pre_reset_count got %0d want 9", count_o);
    end
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-count: count=%0d tc=%0d done=%0d", count_o, tc_o, done_o);
    checks++;
    if (count_o !== 4'd3 || tc_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got count=%0d tc=%0d done=%0d want 3/0/0", count_o, tc_o, done_o);
    end
    #1 reset = 1'b0;
    en_i = 1'b0;
    step();
    checks++;
    if (count_o !== 4'd3) begin
      errors++;
      $display("FAIL hold_after_reset got %0d want 3", count_o);
    end
  endtask

  task automatic test_wrap_load();
    logic [W-1:0] exp_c [4] = '{4'd13, 4'd14, 4'd15, 4'd12};
    logic         exp_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mode_i = WRAP_LOAD; dir_i = DIR_UP; lo_i = 0; hi_i = 15;
    do_load(4'd12);
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("wrap_load step %0d: count=%0d tc=%0d", i, count_o, tc_o);
      checks++;
      if (count_o !== exp_c[i] || tc_o !== exp_t[i]) begin
        errors++;
        $display("FAIL wrap_load[%0d] got count=%0d tc=%0d want %0d/%0d", i, count_o, tc_o, exp_c[i], exp_t[i]);
      end
    end
    en_i = 1'b0;
  endtask

  task automatic test_wrap_bound();
    logic [W-1:0] exp_c [4] = '{4'd3, 4'd2, 4'd6, 4'd5};
    logic         exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    mode_i = WRAP_BOUND; dir_i = DIR_DOWN; lo_i = 2; hi_i = 6;
    do_load(4'd4);
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("wrap_bound step %0d: count=%0d tc=%0d", i, count_o, tc_o);
      checks++;
      if (count_o !== exp_c[i] || tc_o !== exp_t[i]) begin
        errors++;
        $display("FAIL wrap_bound[%0d] got count=%0d tc=%0d want %0d/%0d", i, count_o, tc_o, exp_c[i], exp_t[i]);
      end
    end
    // Out-of-range load terminates on its first enabled cycle.
    dir_i = DIR_UP;
    do_load(4'd9);
    en_i = 1'b1;
    step();
    en_i = 1'b0;
    $display("wrap_bound out-of-range: count=%0d tc=%0d", count_o, tc_o);
    checks++;
    if (count_o !== 4'd2 || tc_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_bound_oor got count=%0d tc=%0d want 2/1", count_o, tc_o);
    end
  endtask

  task automatic test_saturate();
    logic [W-1:0] exp_c [3] = '{4'd5, 4'd5, 4'd5};
    logic         exp_t [3] = '{1'b0, 1'b1, 1'b1};
    mode_i = SATURATE; dir_i = DIR_UP; lo_i = 0; hi_i = 5;
    do_load(4'd4);
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("saturate step %0d: count=%0d tc=%0d", i, count_o, tc_o);
      checks++;
      if (count_o !== exp_c[i] || tc_o !== exp_t[i]) begin
        errors++;
        $display("FAIL saturate[%0d] got count=%0d tc=%0d want %0d/%0d", i, count_o, tc_o, exp_c[i], exp_t[i]);
      end
    end
    // Load on a terminal cycle wins and suppresses tc.
    load_i = 1'b1; load_val_i = 4'd1;
    step();
    load_i = 1'b0; en_i = 1'b0;
    $display("saturate load-over-terminal: count=%0d tc=%0d", count_o, tc_o);
    checks++;
    if (count_o !== 4'd1 || tc_o !== 1'b0) begin
      errors++;
      $display("FAIL saturate_load got count=%0d tc=%0d want 1/0", count_o, tc_o);
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c [6] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic         exp_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    mode_i = ONE_SHOT; dir_i = DIR_DOWN; lo_i = 0; hi_i = 15;
    do_load(4'd2);
    en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      $display("one_shot step %0d: count=%0d tc=%0d done=%0d", i, count_o, tc_o, done_o);
      checks++;
      if (count_o !== exp_c[i] || tc_o !== exp_t[i] || done_o !== exp_d[i]) begin
        errors++;
        $display("FAIL one_shot[%0d] got count=%0d tc=%0d done=%0d want %0d/%0d/%0d",
                 i, count_o, tc_o, done_o, exp_c[i], exp_t[i], exp_d[i]);
      end
    end
    do_load(4'd7);
    checks++;
    if (count_o !== 4'd7 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_reload got count=%0d done=%0d want 7/0", count_o, done_o);
    end
    en_i = 1'b1;
    step();
    checks++;
    if (count_o !== 4'd6) begin
      errors++;
      $display("FAIL one_shot_resume0 got %0d want 6", count_o);
    end
    step();
    en_i = 1'b0;
    $display("one_shot resumed: count=%0d", count_o);
    checks++;
    if (count_o !== 4'd5) begin
      errors++;
      $display("FAIL one_shot_resume1 got %0d want 5", count_o);
    end
  endtask

  task automatic test_bound_err();
    mode_i = WRAP_BOUND; dir_i = DIR_UP; lo_i = 8; hi_i = 3;
    #1;
    checks++;
    if (bound_err_o !== 1'b1) begin
      errors++;
      $display("FAIL bound_err_set got %0d want 1", bound_err_o);
    end
    do_load(4'd5);
    checks++;
    if (count_o !== 4'd5) begin
      errors++;
      $display("FAIL bound_err_load got %0d want 5", count_o);
    end
    en_i = 1'b1;
    step(); step();
    $display("bound_err hold: count=%0d tc=%0d", count_o, tc_o);
    checks++;
    if (count_o !== 4'd5 || tc_o !== 1'b0) begin
      errors++;
      $display("FAIL bound_err_hold got count=%0d tc=%0d want 5/0", count_o, tc_o);
    end
    lo_i = 0; hi_i = 9;
    step();
    en_i = 1'b0;
    $display("bound_err cleared: count=%0d err=%0d", count_o, bound_err_o);
    checks++;
    if (count_o !== 4'd6 || bound_err_o !== 1'b0) begin
      errors++;
      $display("FAIL bound_err_resume got count=%0d err=%0d want 6/0", count_o, bound_err_o);
    end
  endtask

  task automatic test_equal_bounds();
    mode_i = WRAP_BOUND; dir_i = DIR_UP; lo_i = 6; hi_i = 6;
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("equal_bounds step %0d: count=%0d tc=%0d", i, count_o, tc_o);
      checks++;
      if (count_o !== 4'd6 || tc_o !== 1'b1) begin
        errors++;
        $display("FAIL equal_bounds[%0d] got count=%0d tc=%0d want 6/1", i, count_o, tc_o);
      end
    end
    en_i = 1'b0;
    step();
    checks++;
    if (tc_o !== 1'b0 || count_o !== 4'd6) begin
      errors++;
      $display("FAIL equal_bounds_idle got count=%0d tc=%0d want 6/0", count_o, tc_o);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_load();
    test_wrap_bound();
    test_saturate();
    test_one_shot();
    test_bound_err();
    test_equal_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bounded_load_counter
